// File: rtl/bus_arbiter_pkg.sv
// Shared constants for the three-state bus arbiter: FSM encodings, counter width
// and the clog2 helper used to validate the owner index width.
package bus_arbiter_pkg;

    localparam int unsigned TENURE_W = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        TURN  = 2'd2
    } arb_state_t;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned r;
        r = 0;
        while ((64'd1 << r) < 64'(value)) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/bus_rr_select.sv
// Combinational round-robin picker: first requester strictly after `last`,
// wrapping to the lowest requester when none sits above the pointer.
module bus_rr_select
    import bus_arbiter_pkg::*;
#(
    parameter int unsigned N_USERS = 4,
    parameter int unsigned OWNER_W = 2
) (
    input  logic [N_USERS-1:0] req,
    input  logic [OWNER_W-1:0] last,
    output logic [OWNER_W-1:0] sel_c,
    output logic               valid_c
);

    logic               hi_found;
    logic               lo_found;
    logic [OWNER_W-1:0] hi_sel;
    logic [OWNER_W-1:0] lo_sel;

    // Downward scan so the final hit in each class is the lowest index;
    // a pointer beyond N_USERS-1 simply leaves the upper class empty.
    always_comb begin
        hi_found = 1'b0;
        lo_found = 1'b0;
        hi_sel   = '0;
        lo_sel   = '0;
        for (int u = int'(N_USERS) - 1; u >= 0; u--) begin
            if (req[u]) begin
                lo_found = 1'b1;
                lo_sel   = OWNER_W'(u);
                if (u > int'(last)) begin
                    hi_found = 1'b1;
                    hi_sel   = OWNER_W'(u);
                end
            end
        end
        valid_c = lo_found;
        sel_c   = hi_found ? hi_sel : lo_sel;
    end

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin owner of the shared three-state bus: one-hot drive enables,
// capped tenure and a one-cycle all-off turnaround between drivers.
module bus_arbiter
    import bus_arbiter_pkg::*;
#(
    parameter int unsigned N_USERS    = 4,
    parameter int unsigned MAX_TENURE = 8,
    parameter int unsigned OWNER_W    = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [N_USERS-1:0] req,
    output logic [N_USERS-1:0] en,
    output logic               busy,
    output logic [OWNER_W-1:0] owner,
    output logic               turn
);

    if (OWNER_W != clog2(N_USERS)) begin : g_bad_owner_w
        $error("bus_arbiter: OWNER_W must equal clog2(N_USERS)");
    end

    arb_state_t          state;
    logic [TENURE_W-1:0] tenure;
    logic [OWNER_W-1:0]  last;
    logic [OWNER_W-1:0]  sel_c;
    logic                sel_valid_c;

    bus_rr_select #(
        .N_USERS (N_USERS),
        .OWNER_W (OWNER_W)
    ) u_rr_select (
        .req     (req),
        .last    (last),
        .sel_c   (sel_c),
        .valid_c (sel_valid_c)
    );

    // Single registered FSM; TURN arbitrates exactly like IDLE on its one edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            en     <= '0;
            busy   <= 1'b0;
            owner  <= '0;
            turn   <= 1'b0;
            tenure <= '0;
            last   <= OWNER_W'(N_USERS - 1);
        end else begin
            case (state)
                IDLE, TURN: begin
                    turn <= 1'b0;
                    if (sel_valid_c) begin
                        en     <= N_USERS'(1) << sel_c;
                        busy   <= 1'b1;
                        owner  <= sel_c;
                        last   <= sel_c;
                        tenure <= TENURE_W'(1);
                        state  <= GRANT;
                    end else begin
                        state <= IDLE;
                    end
                end
                GRANT: begin
                    // Release on dropped request or expired tenure; no preemption.
                    if (!req[owner] || (tenure == TENURE_W'(MAX_TENURE))) begin
                        en    <= '0;
                        busy  <= 1'b0;
                        turn  <= 1'b1;
                        state <= TURN;
                    end else begin
                        tenure <= tenure + TENURE_W'(1);
                    end
                end
                default: begin
                    en    <= '0;
                    busy  <= 1'b0;
                    turn  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
